alu_share_arbiter: RTL and testbench

- Lets two requesters (e.g. main datapath and a branch/address unit) share one external Arithmetic_Logic_Unit instance.
- Accepts one operation at a time through a valid/ready handshake, with round-robin arbitration.
- Drives the ALU from registered operands, captures result and flags, and returns them on a per-requester response channel.
- Sits between the requesters and the ALU; the ALU stays combinational and unmodified.

---
 rtl/alu_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter letting two requesters share one external
//               combinational ALU. One operation in flight at a time: operands
//               are registered onto the ALU, the result/flags are captured for
//               the owning requester and held until that requester consumes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int              DATA_W   = 32,
    parameter int              SEL_W    = 3,
    parameter logic [SEL_W-1:0] IDLE_SEL = 3'b010
) (
    input  logic              clk,
    input  logic              reset,
    // requester 0
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    output logic              req0_ready,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_ovf,
    // requester 1
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              req1_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_ovf,
    // external ALU
    output logic [DATA_W-1:0] ALU_In1,
    output logic [DATA_W-1:0] ALU_In2,
    output logic [SEL_W-1:0]  ALU_Sel,
    input  logic [DATA_W-1:0] ALU_Output,
    input  logic              ALU_Zero_Flag,
    input  logic              ALU_Overflow_Flag,
    // status
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] r_state;
    logic       r_prio;   // requester favoured on a tie
    logic       r_owner;  // requester whose operation is in flight

    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_owner_rsp_ready;

    // Grant decode: a lone valid wins, a tie goes to the favoured requester.
    // Reset suppresses grants so no accept pulse escapes while held in reset.
    always_comb begin
        w_idle            = (r_state == S_IDLE) && !reset;
        w_grant0          = w_idle && req0_valid && (!req1_valid || !r_prio);
        w_grant1          = w_idle && req1_valid && (!req0_valid ||  r_prio);
        w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign busy       = (r_state != S_IDLE);

    // Arbitration FSM with registered ALU operands and response channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_prio      <= 1'b0;
            r_owner     <= 1'b0;
            ALU_In1     <= '0;
            ALU_In2     <= '0;
            ALU_Sel     <= IDLE_SEL;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp0_ovf    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
            rsp1_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // ALU inputs only move on a grant; otherwise they hold.
                    if (w_grant0) begin
                        ALU_In1 <= req0_a;
                        ALU_In2 <= req0_b;
                        ALU_Sel <= req0_sel;
                        r_owner <= 1'b0;
                        r_state <= S_EXEC;
                    end else if (w_grant1) begin
                        ALU_In1 <= req1_a;
                        ALU_In2 <= req1_b;
                        ALU_Sel <= req1_sel;
                        r_owner <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU has settled on the registered operands; capture for
                    // the owner only, leaving the other channel untouched.
                    if (r_owner) begin
                        rsp1_result <= ALU_Output;
                        rsp1_zero   <= ALU_Zero_Flag;
                        rsp1_ovf    <= ALU_Overflow_Flag;
                        rsp1_valid  <= 1'b1;
                    end else begin
                        rsp0_result <= ALU_Output;
                        rsp0_zero   <= ALU_Zero_Flag;
                        rsp0_ovf    <= ALU_Overflow_Flag;
                        rsp0_valid  <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    // Hold the response until the owner takes it, then hand
                    // priority to the other requester.
                    if (w_owner_rsp_ready) begin
                        if (r_owner) begin
                            rsp1_valid <= 1'b0;
                        end else begin
                            rsp0_valid <= 1'b0;
                        end
                        r_prio  <= ~r_owner;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench for alu_share_arbiter with a
//               behavioural combinational ALU attached to the ALU port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int SW = 3;

    logic          clk;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [SW-1:0] req0_sel, req1_sel;
    logic          rsp0_ready, rsp1_ready;
    wire           req0_ready, req1_ready;
    wire           rsp0_valid, rsp1_valid;
    wire  [DW-1:0] rsp0_result, rsp1_result;
    wire           rsp0_zero, rsp0_ovf, rsp1_zero, rsp1_ovf;
    wire  [DW-1:0] alu_in1, alu_in2;
    wire  [SW-1:0] alu_sel;
    logic [DW-1:0] alu_out;
    logic          alu_zero, alu_ovf;
    wire           busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_share_arbiter #(.DATA_W(DW), .SEL_W(SW), .IDLE_SEL(3'b010)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_ovf(rsp0_ovf),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_ovf(rsp1_ovf),
        .ALU_In1(alu_in1), .ALU_In2(alu_in2), .ALU_Sel(alu_sel),
        .ALU_Output(alu_out), .ALU_Zero_Flag(alu_zero), .ALU_Overflow_Flag(alu_ovf),
        .busy(busy)
    );

    // Behavioural ALU: add / sub / and, signed overflow on add and sub.
    always_comb begin
        alu_out = alu_in1 & alu_in2;
        alu_ovf = 1'b0;
        if (alu_sel == 3'b010) begin
            alu_out = alu_in1 + alu_in2;
            alu_ovf = (alu_in1[DW-1] == alu_in2[DW-1]) && (alu_out[DW-1] != alu_in1[DW-1]);
        end else if (alu_sel == 3'b110) begin
            alu_out = alu_in1 - alu_in2;
            alu_ovf = (alu_in1[DW-1] != alu_in2[DW-1]) && (alu_out[DW-1] != alu_in1[DW-1]);
        end
        alu_zero = (alu_out == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd105; req0_b = 32'd210; req0_sel = 3'b010;
        req1_valid = 1'b1; req1_a = -32'sd100; req1_b = 32'd200; req1_sel = 3'b010;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset held two cycles with both requesters valid.
        tick();
        chk("rst_rdy0_c1", 32'(req0_ready), 32'd0);
        chk("rst_rdy1_c1", 32'(req1_ready), 32'd0);
        tick();
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(alu_sel), 32'd2);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_in2", alu_in2, 32'd0);
        chk("rst_v0", 32'(rsp0_valid), 32'd0);
        chk("rst_v1", 32'(rsp1_valid), 32'd0);
        chk("rst_res0", rsp0_result, 32'd0);
        chk("rst_res1", rsp1_result, 32'd0);
        chk("rst_flags", {28'd0, rsp0_zero, rsp0_ovf, rsp1_zero, rsp1_ovf}, 32'd0);

        // Contention from reset: requester 0 wins first.
        reset = 1'b0;
        #1;
        chk("cont_rdy0", 32'(req0_ready), 32'd1);
        chk("cont_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("cont_exec_rdy1", 32'(req1_ready), 32'd0);
        chk("cont_busy", 32'(busy), 32'd1);
        chk("cont_in1", alu_in1, 32'd105);
        chk("cont_in2", alu_in2, 32'd210);
        tick();
        chk("cont_v0", 32'(rsp0_valid), 32'd1);
        chk("cont_res0", rsp0_result, 32'd315);
        chk("cont_v1_idle", 32'(rsp1_valid), 32'd0);
        tick();
        chk("cont_v0_drop", 32'(rsp0_valid), 32'd0);
        chk("cont_rdy1_turn", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("cont_in1_r1", alu_in1, 32'hFFFF_FF9C);
        tick();
        chk("cont_v1", 32'(rsp1_valid), 32'd1);
        chk("cont_res1", rsp1_result, 32'd100);
        chk("cont_res0_kept", rsp0_result, 32'd315);

        // Next tie goes back to requester 0 (overflow operands);
        // requester 1 queues the backpressure operation.
        req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = -32'sd200;
        tick();
        chk("tie2_rdy0", 32'(req0_ready), 32'd1);
        chk("tie2_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("ovf_v0", 32'(rsp0_valid), 32'd1);
        chk("ovf_res", rsp0_result, 32'h8000_0000);
        chk("ovf_flag", 32'(rsp0_ovf), 32'd1);
        chk("ovf_zero", 32'(rsp0_zero), 32'd0);

        // Requester 1 granted; requester 0 queues the zero-result operation.
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = -32'sd5;
        tick();
        chk("bp_rdy1", 32'(req1_ready), 32'd1);
        chk("bp_rdy0", 32'(req0_ready), 32'd0);
        rsp1_ready = 1'b0;
        tick();
        req1_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_v1", 32'(rsp1_valid), 32'd1);
            chk("bp_hold_res", rsp1_result, 32'hFFFF_FF9C);
            chk("bp_hold_rdy0", 32'(req0_ready), 32'd0);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_release_rdy0", 32'(req0_ready), 32'd0);
        chk("bp_release_v1", 32'(rsp1_valid), 32'd1);
        tick();
        chk("bp_v1_drop", 32'(rsp1_valid), 32'd0);
        chk("bp_grant0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("zero_v0", 32'(rsp0_valid), 32'd1);
        chk("zero_res", rsp0_result, 32'd0);
        chk("zero_flag", 32'(rsp0_zero), 32'd1);
        chk("zero_ovf", 32'(rsp0_ovf), 32'd0);
        tick();

        // Reset during EXEC discards the in-flight operation.
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
        #1;
        chk("mid_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy_clr", 32'(busy), 32'd0);
        chk("mid_v0", 32'(rsp0_valid), 32'd0);
        chk("mid_in1", alu_in1, 32'd0);
        chk("mid_sel", 32'(alu_sel), 32'd2);
        tick();
        chk("mid_v0_after", 32'(rsp0_valid), 32'd0);

        // Priority back at requester 0; single normal operation completes.
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20;
        req1_valid = 1'b1; req1_a = 32'd1;  req1_b = 32'd1;
        #1;
        chk("post_rdy0", 32'(req0_ready), 32'd1);
        chk("post_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("post_in1", alu_in1, 32'd10);
        chk("post_in2", alu_in2, 32'd20);
        tick();
        chk("post_v0", 32'(rsp0_valid), 32'd1);
        chk("post_res", rsp0_result, 32'd30);
        chk("post_flags", {30'd0, rsp0_zero, rsp0_ovf}, 32'd0);
        chk("post_v1", 32'(rsp1_valid), 32'd0);
        tick();
        chk("post_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
